// File: rtl/pn15_pkg.sv
// -----------------------------------------------------------------------------
// pn15_pkg
// Shared definitions for the PN15 sequence F(x) = x^15 + x^14 + 1.
// The generator and the checker both import this package, so the two ends
// always agree on the polynomial taps.
//
// Contents:
//   state_t       checker FSM states (SEED, VERIFY, LOCKED)
//   PN_LEN        shift register length (15)
//   TAP_A, TAP_B  feedback taps into the history register (14, 13)
//   PN_ZERO       the all-zero register value, which the sequence never enters
//   pn15_predict  next bit predicted from a history word
//   pn15_shift    history update with a new bit entering at position 0
// -----------------------------------------------------------------------------
package pn15_pkg;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int PN_LEN = 15;
  localparam int TAP_A  = 14;
  localparam int TAP_B  = 13;

  localparam logic [PN_LEN-1:0] PN_ZERO = 15'h0;

  // hist[0] is the newest bit, so the taps select the bits received
  // 15 and 14 positions ago.
  function automatic logic pn15_predict(input logic [PN_LEN-1:0] hist);
    return hist[TAP_A] ^ hist[TAP_B];
  endfunction

  function automatic logic [PN_LEN-1:0] pn15_shift(input logic [PN_LEN-1:0] hist,
                                                   input logic              x);
    return {hist[PN_LEN-2:0], x};
  endfunction

endpackage

// File: rtl/pn15_err_window.sv
// -----------------------------------------------------------------------------
// pn15_err_window
// Sliding (non-overlapping) error window for the PN15 checker. Counts accepted
// bits and mismatches while the checker is locked; raises drop_lock in the same
// cycle as the accepted bit that brings the window error count to ERR_THR.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   clear      in   zero the window (used on entry to LOCKED)
//   step       in   an accepted bit is being checked this cycle
//   err        in   that bit mismatched the reference (qualified by step)
//   drop_lock  out  combinational strobe: error threshold reached on this bit
// -----------------------------------------------------------------------------
module pn15_err_window #(
  parameter int ERR_WIN = 64,
  parameter int ERR_THR = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic step,
  input  logic err,
  output logic drop_lock
);

  localparam int WIN_W = $clog2(ERR_WIN + 1);
  localparam int ERR_W = $clog2(ERR_THR + 1);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(ERR_WIN - 1);
  localparam logic [ERR_W-1:0] THR_LAST = ERR_W'(ERR_THR - 1);

  logic [WIN_W-1:0] win_cnt_reg, win_cnt_next;
  logic [ERR_W-1:0] win_err_reg, win_err_next;
  logic             win_end;

  // The error counter never exceeds ERR_THR-1 while locked (reaching the
  // threshold drops lock and zeroes it), so an equality compare is enough.
  assign drop_lock = step && err && (win_err_reg == THR_LAST);
  assign win_end   = step && (win_cnt_reg == WIN_LAST);

  always_comb begin
    win_cnt_next = win_cnt_reg;
    win_err_next = win_err_reg;
    // drop_lock wins over win_end: both zero the window, and the top level
    // acts on drop_lock only.
    if (clear || drop_lock || win_end) begin
      win_cnt_next = '0;
      win_err_next = '0;
    end else if (step) begin
      win_cnt_next = win_cnt_reg + WIN_W'(1);
      win_err_next = win_err_reg + ERR_W'(err);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_reg <= '0;
      win_err_reg <= '0;
    end else begin
      win_cnt_reg <= win_cnt_next;
      win_err_reg <= win_err_next;
    end
  end

endmodule

// File: rtl/pn15_checker.sv
// -----------------------------------------------------------------------------
// pn15_checker
// Receive-side checker for the PN15 stream (x^15 + x^14 + 1). Seeds its
// history from the incoming bits, verifies SYNC_LEN consecutive predictions,
// then free-runs its own reference and counts bit errors. Too many errors in
// one ERR_WIN window drop lock and restart seeding.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   din        in   received PN bit
//   din_valid  in   din is accepted on this edge when 1
//   clr_cnt    in   synchronous clear of bit_cnt / err_cnt (wins over counting)
//   locked     out  checker is in LOCKED
//   bit_err    out  one-cycle pulse: last accepted bit mismatched (LOCKED only)
//   lock_lost  out  one-cycle pulse on LOCKED -> SEED
//   bit_cnt    out  bits checked while locked, saturating
//   err_cnt    out  errors seen while locked, saturating
// -----------------------------------------------------------------------------
module pn15_checker
  import pn15_pkg::*;
#(
  parameter int SYNC_LEN = 32,
  parameter int ERR_WIN  = 64,
  parameter int ERR_THR  = 8,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             bit_err,
  output logic             lock_lost,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [3:0]       FILL_LAST = 4'(PN_LEN - 1);
  localparam logic [7:0]       SYNC_LAST = 8'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  // FSM and datapath state
  state_t            state_reg, state_next;
  logic [PN_LEN-1:0] hist_reg, hist_next;
  logic [3:0]        fill_cnt_reg, fill_cnt_next;
  logic [7:0]        match_cnt_reg, match_cnt_next;

  // Registered outputs
  logic              locked_reg, locked_next;
  logic              bit_err_reg, bit_err_next;
  logic              lock_lost_reg, lock_lost_next;
  logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [CNT_W-1:0]  err_cnt_reg, err_cnt_next;

  logic pred;
  logic miss;
  logic step;
  logic win_clear;
  logic drop_lock;

  assign pred = pn15_predict(hist_reg);
  assign miss = din ^ pred;
  assign step = din_valid && (state_reg == LOCKED);

  pn15_err_window #(
    .ERR_WIN (ERR_WIN),
    .ERR_THR (ERR_THR)
  ) u_err_window (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (win_clear),
    .step      (step),
    .err       (miss),
    .drop_lock (drop_lock)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= SEED;
      hist_reg      <= PN_ZERO;
      fill_cnt_reg  <= '0;
      match_cnt_reg <= '0;
      locked_reg    <= 1'b0;
      bit_err_reg   <= 1'b0;
      lock_lost_reg <= 1'b0;
      bit_cnt_reg   <= '0;
      err_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      hist_reg      <= hist_next;
      fill_cnt_reg  <= fill_cnt_next;
      match_cnt_reg <= match_cnt_next;
      locked_reg    <= locked_next;
      bit_err_reg   <= bit_err_next;
      lock_lost_reg <= lock_lost_next;
      bit_cnt_reg   <= bit_cnt_next;
      err_cnt_reg   <= err_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    hist_next      = hist_reg;
    fill_cnt_next  = fill_cnt_reg;
    match_cnt_next = match_cnt_reg;
    win_clear      = 1'b0;

    if (din_valid) begin
      unique case (state_reg)
        SEED: begin
          hist_next = pn15_shift(hist_reg, din);
          if (fill_cnt_reg == FILL_LAST) begin
            fill_cnt_next = '0;
            // An all-zero history is the one state the LFSR never visits;
            // refill rather than verify against a dead sequence.
            if (hist_next != PN_ZERO) begin
              state_next     = VERIFY;
              match_cnt_next = '0;
            end
          end else begin
            fill_cnt_next = fill_cnt_reg + 4'd1;
          end
        end

        VERIFY: begin
          // Still self-synchronising: the received bit feeds the history.
          hist_next = pn15_shift(hist_reg, din);
          if (miss) begin
            state_next    = SEED;
            fill_cnt_next = '0;
          end else if (match_cnt_reg == SYNC_LAST) begin
            state_next     = LOCKED;
            match_cnt_next = '0;
            win_clear      = 1'b1;
          end else begin
            match_cnt_next = match_cnt_reg + 8'd1;
          end
        end

        LOCKED: begin
          // Free-running reference so a bad received bit is not fed back
          // into later predictions.
          hist_next = pn15_shift(hist_reg, pred);
          if (drop_lock) begin
            state_next    = SEED;
            fill_cnt_next = '0;
          end
        end

        default: begin
          state_next    = SEED;
          fill_cnt_next = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic (values registered by the state register process)
  // ---------------------------------------------------------------------------
  always_comb begin
    locked_next    = (state_next == LOCKED);
    bit_err_next   = step && miss;
    lock_lost_next = drop_lock;
    bit_cnt_next   = bit_cnt_reg;
    err_cnt_next   = err_cnt_reg;

    // A clear on the same cycle as an accepted bit discards that bit's count.
    if (clr_cnt) begin
      bit_cnt_next = '0;
      err_cnt_next = '0;
    end else if (step) begin
      if (bit_cnt_reg != CNT_MAX) begin
        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
      end
      if (miss && (err_cnt_reg != CNT_MAX)) begin
        err_cnt_next = err_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign locked    = locked_reg;
  assign bit_err   = bit_err_reg;
  assign lock_lost = lock_lost_reg;
  assign bit_cnt   = bit_cnt_reg;
  assign err_cnt   = err_cnt_reg;

endmodule
